// File: rtl/fir_out_requant_pkg.sv
// Shared types and widths for the FIR output re-quantiser (package fir_pkg).
package fir_pkg;

    localparam int FIR_IN_W  = 32;
    localparam int FIR_OUT_W = 16;
    localparam int FIR_SHIFT = 15;

    typedef logic signed [FIR_IN_W-1:0]  fir_in_t;
    typedef logic signed [FIR_OUT_W-1:0] fir_out_t;

    typedef struct packed {
        fir_out_t data;
        logic     last;
        logic     sat;
    } fir_beat_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } skid_state_t;

endpackage

// File: rtl/fir_out_requant_if.sv
// AXI-stream bundle used on both sides of the re-quantiser; W is the tdata width.
interface fir_axis_if #(
    parameter int W = 32
) ();

    logic [W-1:0]   tdata;
    logic [W/8-1:0] tkeep;
    logic           tlast;
    logic           tuser;
    logic           tvalid;
    logic           tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/fir_out_requant_core.sv
// Combinational round-half-up, arithmetic shift and saturate; returns the sample plus a saturation flag.
module fir_requant_core #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o,
    output logic                    sat_o
);

    localparam int EW = IN_W + 1;
    typedef logic signed [EW-1:0] ext_t;

    // One guard bit keeps the rounding add from overflowing.
    localparam ext_t RND  = (SHIFT == 0) ? ext_t'(0)
                                         : (ext_t'(1) <<< ((SHIFT == 0) ? 0 : SHIFT - 1));
    localparam ext_t MAXV = ext_t'({1'b0, {(OUT_W-1){1'b1}}});
    localparam ext_t MINV = -MAXV - ext_t'(1);

    function automatic ext_t round_shift(input logic signed [IN_W-1:0] x);
        ext_t r;
        r = ext_t'(x) + RND;
        return r >>> SHIFT;
    endfunction

    function automatic logic [OUT_W:0] saturate(input ext_t q);
        logic [OUT_W:0] res;
        if (q > MAXV) begin
            res = {1'b1, MAXV[OUT_W-1:0]};
        end else if (q < MINV) begin
            res = {1'b1, MINV[OUT_W-1:0]};
        end else begin
            res = {1'b0, q[OUT_W-1:0]};
        end
        return res;
    endfunction

    always_comb begin
        {sat_o, out_o} = saturate(round_shift(in_i));
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output re-quantiser: 32-bit signed stream in, 16-bit saturated stream out through a 2-entry skid buffer.
// Optional saturation counter enabled by defining FIR_REQ_SATCNT_EN.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_IN_W,
    parameter int OUT_W = FIR_OUT_W,
    parameter int SHIFT = FIR_SHIFT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    fir_axis_if.slave        s_axis,
    fir_axis_if.master       m_axis,
    output logic [CNT_W-1:0] sat_count
);

    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic                    last;
        logic                    sat;
    } beat_t;

    skid_state_t state_q, state_d;
    beat_t       or_q, or_d;
    beat_t       sk_q, sk_d;
    beat_t       new_beat;
    logic        s_ready_q, s_ready_d;
    logic        accept;
    logic        emit;

    logic signed [IN_W-1:0]  in_data;
    logic signed [OUT_W-1:0] core_out;
    logic                    core_sat;
    logic                    unused_keep;

    assign in_data     = s_axis.tdata;
    assign unused_keep = ^s_axis.tkeep;

    fir_requant_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_core (
        .in_i  (in_data),
        .out_o (core_out),
        .sat_o (core_sat)
    );

    assign new_beat = '{data: core_out, last: s_axis.tlast, sat: core_sat};
    assign accept   = s_axis.tvalid && s_ready_q;
    assign emit     = (state_q != ST_EMPTY) && m_axis.tready;

    always_comb begin
        state_d = state_q;
        or_d    = or_q;
        sk_d    = sk_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d = ST_ONE;
                    or_d    = new_beat;
                end
            end
            ST_ONE: begin
                if (accept && emit) begin
                    or_d = new_beat;
                end else if (accept) begin
                    state_d = ST_FULL;
                    sk_d    = new_beat;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // tready is low here, so only a drain can happen.
                if (emit) begin
                    state_d = ST_ONE;
                    or_d    = sk_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        s_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_EMPTY;
            s_ready_q <= 1'b0;
            or_q      <= '0;
            sk_q      <= '0;
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            or_q      <= or_d;
            sk_q      <= sk_d;
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = (state_q != ST_EMPTY);
    assign m_axis.tdata  = or_q.data;
    assign m_axis.tlast  = or_q.last;
    assign m_axis.tuser  = or_q.sat;
    assign m_axis.tkeep  = (state_q != ST_EMPTY) ? '1 : '0;

`ifdef FIR_REQ_SATCNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (emit && or_q.sat && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_count = cnt_q;
`else
    assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: rounding/saturation edges, backpressure, mid-stream reset, streaming.
module tb_fir_out_requant;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sat_count;

    fir_axis_if #(.W(32)) s_if ();
    fir_axis_if #(.W(16)) m_if ();

    fir_out_requant dut (
        .clk       (clk),
        .reset     (reset),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [31:0] din,
                          input logic [15:0] dout, input logic dsat);
        s_if.tdata  = din;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        step();
        s_if.tvalid = 1'b0;
        check_val({tag, "_vld"},  32'(m_if.tvalid), 32'd1);
        check_val({tag, "_data"}, 32'(m_if.tdata),  32'(dout));
        check_val({tag, "_user"}, 32'(m_if.tuser),  32'(dsat));
        step();
    endtask

    logic [31:0] bp_data [3] = '{32'h0000_4000, 32'h0001_0000, 32'h0001_8000};
    logic [15:0] gd [3];
    logic        gl [3];
    logic        rdy, v;
    logic [15:0] exp16;
    int          idx, got, first_c, last_c;
    int          acc, outn, bad, cyc;

    initial begin
        reset       = 1'b1;
        s_if.tdata  = '0;
        s_if.tkeep  = '1;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        step();
        step();
        check_val("rst_sready", 32'(s_if.tready),  32'd0);
        check_val("rst_mvalid", 32'(m_if.tvalid),  32'd0);
        check_val("rst_tdata",  32'(m_if.tdata),   32'd0);
        check_val("rst_tkeep",  32'(m_if.tkeep),   32'd0);
        check_val("rst_tlast",  32'(m_if.tlast),   32'd0);
        check_val("rst_tuser",  32'(m_if.tuser),   32'd0);
        check_val("rst_satcnt", 32'(sat_count),    32'd0);
        reset = 1'b0;
        step();
        check_val("post_rst_sready", 32'(s_if.tready), 32'd1);

        single("rnd_half",    32'h0000_4000, 16'd1,      1'b0);
        single("rnd_below",   32'h0000_3FFF, 16'd0,      1'b0);
        single("rnd_neghalf", 32'hFFFF_C000, 16'd0,      1'b0);
        single("pos_max",     32'h3FFF_8000, 16'h7FFF,   1'b0);
        single("pos_sat",     32'h4000_0000, 16'h7FFF,   1'b1);
        single("neg_min",     32'hC000_0000, 16'h8000,   1'b0);
        single("neg_sat",     32'hBFFF_0000, 16'h8000,   1'b1);
        check_val("idle_tkeep", 32'(m_if.tkeep), 32'd0);
`ifdef FIR_REQ_SATCNT_EN
        check_val("satcnt_single", 32'(sat_count), 32'd2);
`else
        check_val("satcnt_single", 32'(sat_count), 32'd0);
`endif

        // Backpressure: three beats offered while downstream stalls for 6 cycles.
        m_if.tready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            s_if.tvalid = (idx < 3);
            s_if.tdata  = bp_data[(idx < 3) ? idx : 2];
            s_if.tlast  = (idx == 2);
            rdy = s_if.tready;
            step();
            if (rdy && s_if.tvalid) idx++;
        end
        check_val("bp_accepted", 32'(idx),          32'd2);
        check_val("bp_sready",   32'(s_if.tready),  32'd0);
        check_val("bp_hold_vld", 32'(m_if.tvalid),  32'd1);
        check_val("bp_hold_dat", 32'(m_if.tdata),   32'd1);
        check_val("bp_tkeep",    32'(m_if.tkeep),   32'h3);

        m_if.tready = 1'b1;
        got = 0;
        first_c = 0;
        last_c = 0;
        for (int c = 0; c < 10 && got < 3; c++) begin
            if (m_if.tvalid) begin
                gd[got] = m_if.tdata;
                gl[got] = m_if.tlast;
                if (got == 0) first_c = c;
                last_c = c;
                got++;
            end
            rdy = s_if.tready;
            v   = s_if.tvalid;
            step();
            if (rdy && v) begin
                idx++;
                if (idx >= 3) begin
                    s_if.tvalid = 1'b0;
                    s_if.tlast  = 1'b0;
                end else begin
                    s_if.tdata = bp_data[idx];
                    s_if.tlast = (idx == 2);
                end
            end
        end
        check_val("bp_count",   32'(got),                32'd3);
        check_val("bp_span",    32'(last_c - first_c),   32'd2);
        check_val("bp_d0",      32'(gd[0]),              32'd1);
        check_val("bp_d1",      32'(gd[1]),              32'd2);
        check_val("bp_d2",      32'(gd[2]),              32'd3);
        check_val("bp_l0",      32'(gl[0]),              32'd0);
        check_val("bp_l1",      32'(gl[1]),              32'd0);
        check_val("bp_l2",      32'(gl[2]),              32'd1);
        check_val("bp_drained", 32'(m_if.tvalid),        32'd0);

        // Fill both entries, then reset while the input keeps offering.
        m_if.tready = 1'b0;
        s_if.tdata  = 32'h0000_4000;
        s_if.tlast  = 1'b0;
        s_if.tvalid = 1'b1;
        step();
        step();
        check_val("full_sready", 32'(s_if.tready), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_if.tvalid = 1'b0;
        check_val("mid_rst_mvalid", 32'(m_if.tvalid), 32'd0);
        check_val("mid_rst_sready", 32'(s_if.tready), 32'd0);
        step();
        check_val("mid_rst_rdy_up", 32'(s_if.tready), 32'd1);
        check_val("mid_rst_empty",  32'(m_if.tvalid), 32'd0);
        m_if.tready = 1'b1;
        step();
        step();
        check_val("mid_rst_nostale", 32'(m_if.tvalid), 32'd0);
        check_val("mid_rst_satcnt",  32'(sat_count),   32'd0);

        // 1000 back-to-back beats, every 10th saturating.
        acc  = 0;
        outn = 0;
        bad  = 0;
        cyc  = 0;
        m_if.tready = 1'b1;
        while ((acc < 1000 || m_if.tvalid) && cyc < 1100) begin
            if (acc < 1000) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = (acc % 10 == 9) ? 32'h7FFF_FFFF : (32'(acc) << 15);
            end else begin
                s_if.tvalid = 1'b0;
            end
            rdy = s_if.tready;
            v   = s_if.tvalid;
            if (m_if.tvalid) begin
                exp16 = (outn % 10 == 9) ? 16'h7FFF : 16'(outn);
                if (m_if.tdata !== exp16 || m_if.tuser !== (outn % 10 == 9)) bad++;
                outn++;
            end
            step();
            cyc++;
            if (rdy && v) acc++;
        end
        check_val("stream_acc",    32'(acc),       32'd1000);
        check_val("stream_out",    32'(outn),      32'd1000);
        check_val("stream_bad",    32'(bad),       32'd0);
        check_val("stream_cycles", 32'(cyc),       32'd1001);
`ifdef FIR_REQ_SATCNT_EN
        check_val("stream_satcnt", 32'(sat_count), 32'd100);
`else
        check_val("stream_satcnt", 32'(sat_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_out_requant.md
Name: fir_out_requant

Overview:
- Downstream stage of the FIR filter. Consumes the FIR's 32-bit signed AXI-stream output and re-quantises it to 16-bit signed samples.
- Arithmetic: round-half-up, arithmetic right shift, saturate. A per-sample saturation flag is emitted with each sample.
- Fully registered AXI-stream slave/master with a 2-entry skid buffer, so both tready paths are registered and the chain runs at 100 MHz.

Parameters:
- IN_W, 32, input sample width (FIR m_axis_fir_tdata)
- OUT_W, 16, output sample width
- SHIFT, 15, right-shift amount (FIR coefficients are Q15); SHIFT=0 means no rounding add
- CNT_W, 16, saturation counter width (optional feature only)

Ports:
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high reset
- s_axis_tdata  in  IN_W  signed FIR output sample
- s_axis_tkeep  in  IN_W/8  ignored; accepted for interface compatibility
- s_axis_tlast  in  1  end-of-frame marker
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  block can accept a beat
- m_axis_tdata  out  OUT_W  signed re-quantised sample
- m_axis_tkeep  out  OUT_W/8  all ones while m_axis_tvalid=1, else 0
- m_axis_tlast  out  1  tlast of the corresponding input beat
- m_axis_tuser  out  1  1 = this sample was saturated
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream accepts
- sat_count  out  CNT_W  saturation events; driven only with FIR_REQ_SATCNT_EN, else tied 0

Behaviour:
- Reset (sync, active-high), all outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0, sat_count=0.
  - Both buffer entries are invalidated; in-flight data is dropped.
  - s_axis_tready rises in the first cycle after reset deasserts.
- Transfers: accept on s_axis_tvalid&&s_axis_tready; emit on m_axis_tvalid&&m_axis_tready.
- Arithmetic, all in IN_W+1 bits signed:
  - r = in + 2^(SHIFT-1)
  - q = r >>> SHIFT
  - if q > 2^(OUT_W-1)-1: out = 2^(OUT_W-1)-1, tuser=1
  - if q < -2^(OUT_W-1): out = -2^(OUT_W-1), tuser=1
  - otherwise out = q[OUT_W-1:0], tuser=0
- Latency: exactly 1 cycle from accept to m_axis_tvalid when the output register is empty or draining.
- Buffering: output register (OR) plus skid register (SK). States:
  - EMPTY (OR invalid, SK invalid)
  - ONE (OR valid, SK invalid)
  - FULL (OR valid, SK valid)
- Transitions:
  - EMPTY + accept -> ONE
  - ONE + accept + no emit -> FULL; the new beat goes to SK
  - ONE + accept + emit -> ONE; OR is reloaded
  - ONE + emit + no accept -> EMPTY
  - FULL + emit -> ONE; SK moves to OR
  - A FULL state with an accept is impossible
- s_axis_tready is a register equal to (next state != FULL).
- AXI stability: while m_axis_tvalid=1 and m_axis_tready=0, tdata/tlast/tuser/tkeep hold constant.
- Ordering is strictly preserved. tlast and tuser travel with their data through SK.
- Simultaneous accept and emit in ONE: emit the old OR contents, load the new one; no bubble. Sustained throughput is 1 beat/clk.
- Reset mid-operation takes priority over any transfer in the same cycle.

Optional Feature:
- Macro FIR_REQ_SATCNT_EN.
- Defined:
  - sat_count increments by 1 on every emitted beat with tuser=1.
  - It saturates at 2^CNT_W-1 (no wrap) and clears only on reset.
- Undefined: the counter logic is absent and sat_count is tied to 0.

Decomposition:
- Package fir_pkg holds:
  - FIR_IN_W=32, FIR_OUT_W=16, FIR_SHIFT=15
  - typedef fir_in_t (signed [31:0]) and fir_out_t (signed [15:0])
  - typedef fir_beat_t: struct {data, last, sat}
- One sub-module, fir_requant_core: a purely combinational round/shift/saturate function (IN_W, OUT_W, SHIFT) returning {out, sat}.
- Skid/state logic lives in the top.

Test Plan:
- Rounding: in 0x00004000 -> out 1, tuser 0. In 0x00003FFF -> out 0. In 0xFFFFC000 -> out 0 (half rounds up).
- Positive edge: in 0x3FFF8000 -> out 32767, tuser 0. In 0x40000000 -> out 32767, tuser 1.
- Negative edge: in 0xC0000000 -> out -32768, tuser 0. In 0xBFFF0000 -> out -32768, tuser 1.
- Backpressure: m_axis_tready=0 for 6 cycles while 3 beats are offered.
  - Exactly 2 are accepted and s_axis_tready is 0 in the following cycle.
  - After release, all 3 emerge in order, one per cycle, with tlast preserved (third beat tlast=1).
- Reset mid-stream: in FULL, assert reset 1 cycle.
  - Next cycle m_axis_tvalid=0, s_axis_tready=0.
  - The cycle after, s_axis_tready=1 and no stale beats appear.
- Streaming with FIR_REQ_SATCNT_EN: 1000 back-to-back beats with m_axis_tready=1, every 10th being 0x7FFFFFFF.
  - Exactly 1000 outputs, 1 beat per cycle after 1-cycle latency.
  - sat_count=100.
